// File: rtl/ibufds_diff_filter.sv
// rtl/ibufds_diff_filter.sv - synchronised, glitch-filtered differential pair receiver
// Optional per-channel polarity inversion input INV is enabled by `define IBUFDS_DIFF_FILTER_POL_INV_EN.
module ibufds_diff_filter #(
  parameter int    WIDTH      = 4,
  parameter int    FILTER_LEN = 3,
  parameter int    INV_LIMIT  = 4,
  parameter string IOSTANDARD = "LVDS_25"
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] I,
  input  logic [WIDTH-1:0] IB,
  input  logic             ERR_CLR,
`ifdef IBUFDS_DIFF_FILTER_POL_INV_EN
  input  logic [WIDTH-1:0] INV,
`endif
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] OB,
  output logic [WIDTH-1:0] VALID,
  output logic [WIDTH-1:0] ERR
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int IW = $clog2(INV_LIMIT + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [IW-1:0] INV_MAX   = IW'(INV_LIMIT);
  localparam logic [IW-1:0] INV_LAST  = IW'(INV_LIMIT - 1);
  localparam string unused_iostandard = IOSTANDARD;

  logic [WIDTH-1:0] i_meta;
  logic [WIDTH-1:0] ib_meta;
  logic [WIDTH-1:0] s_i;
  logic [WIDTH-1:0] s_ib;
  logic [WIDTH-1:0] cand;

  // Reset to a valid pair (I=0, IB=1) so no spurious invalid sample follows reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      i_meta  <= '0;
      s_i     <= '0;
      ib_meta <= '1;
      s_ib    <= '1;
    end else begin
      i_meta  <= I;
      s_i     <= i_meta;
      ib_meta <= IB;
      s_ib    <= ib_meta;
    end
  end

`ifdef IBUFDS_DIFF_FILTER_POL_INV_EN
  logic [WIDTH-1:0] inv_meta;
  logic [WIDTH-1:0] s_inv;

  // INV is synchronised alongside the pins so a polarity flip filters like a data change
  always_ff @(posedge CLK) begin
    if (RST) begin
      inv_meta <= '0;
      s_inv    <= '0;
    end else begin
      inv_meta <= INV;
      s_inv    <= inv_meta;
    end
  end

  assign cand = s_i ^ s_inv;
`else
  assign cand = s_i;
`endif

  for (genvar n = 0; n < WIDTH; n++) begin : g_ch
    logic          o_q;
    logic          valid_q;
    logic          err_q;
    logic [FW-1:0] fcnt;
    logic [IW-1:0] icnt;
    logic          sample_ok;
    logic          reach;

    assign sample_ok = s_i[n] ^ s_ib[n];
    assign reach     = !sample_ok && (icnt == INV_LAST);

    always_ff @(posedge CLK) begin
      if (RST) begin
        o_q     <= 1'b0;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        fcnt    <= '0;
        icnt    <= '0;
      end else begin
        if (sample_ok) begin
          icnt    <= '0;
          valid_q <= 1'b1;
          if (cand[n] == o_q) begin
            fcnt <= '0;
          end else if (fcnt == FILT_LAST) begin
            o_q  <= cand[n];
            fcnt <= '0;
          end else begin
            fcnt <= fcnt + FW'(1);
          end
        end else begin
          // Invalid samples freeze the filter; only the timeout counter moves
          if (icnt != INV_MAX) begin
            icnt <= icnt + IW'(1);
          end
          if (reach) begin
            valid_q <= 1'b0;
          end
        end

        if (reach) begin
          err_q <= 1'b1;
        end else if (ERR_CLR) begin
          err_q <= 1'b0;
        end
      end
    end

    assign O[n]     = o_q;
    assign VALID[n] = valid_q;
    assign ERR[n]   = err_q;
  end

  assign OB = ~O;

endmodule

// File: tb/tb_ibufds_diff_filter.sv
// tb/tb_ibufds_diff_filter.sv - self-checking bench for ibufds_diff_filter
module tb_ibufds_diff_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic       err_clr;
  logic [3:0] i_pin;
  logic [3:0] ib_pin;
  logic [3:0] inv;
  logic [3:0] o;
  logic [3:0] ob;
  logic [3:0] valid;
  logic [3:0] err;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic       rst;
    logic [3:0] i;
    logic [3:0] ib;
    logic       clr;
    logic [3:0] o;
    logic [3:0] valid;
    logic [3:0] err;
    logic       vchk;
  } vec_t;

  typedef struct {
    logic [3:0] o;
    logic [3:0] valid;
    logic [3:0] err;
    logic       vchk;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  ibufds_diff_filter #(
    .WIDTH(4),
    .FILTER_LEN(3),
    .INV_LIMIT(4),
    .IOSTANDARD("LVDS_25")
  ) dut (
    .CLK(clk),
    .RST(rst),
    .I(i_pin),
    .IB(ib_pin),
    .ERR_CLR(err_clr),
`ifdef IBUFDS_DIFF_FILTER_POL_INV_EN
    .INV(inv),
`endif
    .O(o),
    .OB(ob),
    .VALID(valid),
    .ERR(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] iv, input logic [3:0] ibv, input logic c,
                     input logic [3:0] ov, input logic [3:0] vv, input logic [3:0] ev, input logic vc);
    vec_t v;
    v.rst = r; v.i = iv; v.ib = ibv; v.clr = c;
    v.o = ov; v.valid = vv; v.err = ev; v.vchk = vc;
    vecs.push_back(v);
  endtask

  initial begin
    exp_t       e;
    logic [3:0] ob_exp;
    int         cyc;

    rst = 1'b1; err_clr = 1'b0; i_pin = 4'hF; ib_pin = 4'h0; inv = 4'h0;

    // reset, then release with all channels driving 1
    add(1, 4'hF, 4'h0, 0, 4'h0, 4'h0, 4'h0, 1);
    add(1, 4'hF, 4'h0, 0, 4'h0, 4'h0, 4'h0, 1);
    add(0, 4'hF, 4'h0, 0, 4'h0, 4'hF, 4'h0, 0);
    add(0, 4'hF, 4'h0, 0, 4'h0, 4'hF, 4'h0, 0);
    add(0, 4'hF, 4'h0, 0, 4'h0, 4'hF, 4'h0, 1);
    add(0, 4'hF, 4'h0, 0, 4'h0, 4'hF, 4'h0, 1);
    add(0, 4'hF, 4'h0, 0, 4'hF, 4'hF, 4'h0, 1);
    // ch0 two-cycle glitch, then a real change needing the full filter length
    add(0, 4'hE, 4'h1, 0, 4'hF, 4'hF, 4'h0, 1);
    add(0, 4'hE, 4'h1, 0, 4'hF, 4'hF, 4'h0, 1);
    add(0, 4'hF, 4'h0, 0, 4'hF, 4'hF, 4'h0, 1);
    add(0, 4'hF, 4'h0, 0, 4'hF, 4'hF, 4'h0, 1);
    add(0, 4'hF, 4'h0, 0, 4'hF, 4'hF, 4'h0, 1);
    add(0, 4'hE, 4'h1, 0, 4'hF, 4'hF, 4'h0, 1);
    add(0, 4'hE, 4'h1, 0, 4'hF, 4'hF, 4'h0, 1);
    add(0, 4'hE, 4'h1, 0, 4'hF, 4'hF, 4'h0, 1);
    add(0, 4'hE, 4'h1, 0, 4'hF, 4'hF, 4'h0, 1);
    add(0, 4'hE, 4'h1, 0, 4'hE, 4'hF, 4'h0, 1);
    // ch1 invalid for 4 cycles
    add(0, 4'hE, 4'h3, 0, 4'hE, 4'hF, 4'h0, 1);
    add(0, 4'hE, 4'h3, 0, 4'hE, 4'hF, 4'h0, 1);
    add(0, 4'hE, 4'h3, 0, 4'hE, 4'hF, 4'h0, 1);
    add(0, 4'hE, 4'h3, 0, 4'hE, 4'hF, 4'h0, 1);
    add(0, 4'hE, 4'h1, 0, 4'hE, 4'hF, 4'h0, 1);
    add(0, 4'hE, 4'h1, 0, 4'hE, 4'hD, 4'h2, 1);
    add(0, 4'hE, 4'h1, 0, 4'hE, 4'hF, 4'h2, 1);
    add(0, 4'hE, 4'h1, 0, 4'hE, 4'hF, 4'h2, 1);
    // ch2 timeout coincident with ERR_CLR, then a plain clear
    add(0, 4'hE, 4'h5, 0, 4'hE, 4'hF, 4'h2, 1);
    add(0, 4'hE, 4'h5, 0, 4'hE, 4'hF, 4'h2, 1);
    add(0, 4'hE, 4'h5, 0, 4'hE, 4'hF, 4'h2, 1);
    add(0, 4'hE, 4'h5, 0, 4'hE, 4'hF, 4'h2, 1);
    add(0, 4'hE, 4'h1, 0, 4'hE, 4'hF, 4'h2, 1);
    add(0, 4'hE, 4'h1, 1, 4'hE, 4'hB, 4'h4, 1);
    add(0, 4'hE, 4'h1, 0, 4'hE, 4'hF, 4'h4, 1);
    add(0, 4'hE, 4'h1, 1, 4'hE, 4'hF, 4'h0, 1);
    add(0, 4'hE, 4'h1, 0, 4'hE, 4'hF, 4'h0, 1);
    // ch3: differing, invalid, differing, differing
    add(0, 4'h6, 4'h9, 0, 4'hE, 4'hF, 4'h0, 1);
    add(0, 4'h6, 4'h1, 0, 4'hE, 4'hF, 4'h0, 1);
    add(0, 4'h6, 4'h9, 0, 4'hE, 4'hF, 4'h0, 1);
    add(0, 4'h6, 4'h9, 0, 4'hE, 4'hF, 4'h0, 1);
    add(0, 4'h6, 4'h9, 0, 4'hE, 4'hF, 4'h0, 1);
    // ch0 partial filter count, then reset (with ERR_CLR) must discard it
    add(0, 4'h7, 4'h8, 0, 4'h6, 4'hF, 4'h0, 1);
    add(0, 4'h7, 4'h8, 0, 4'h6, 4'hF, 4'h0, 1);
    add(0, 4'h7, 4'h8, 0, 4'h6, 4'hF, 4'h0, 1);
    add(0, 4'h7, 4'h8, 0, 4'h6, 4'hF, 4'h0, 1);
    add(1, 4'h7, 4'h8, 1, 4'h0, 4'h0, 4'h0, 1);
    add(1, 4'hF, 4'h0, 0, 4'h0, 4'h0, 4'h0, 1);
    add(0, 4'hF, 4'h0, 0, 4'h0, 4'hF, 4'h0, 0);
    add(0, 4'hF, 4'h0, 0, 4'h0, 4'hF, 4'h0, 0);
    add(0, 4'hF, 4'h0, 0, 4'h0, 4'hF, 4'h0, 1);
    add(0, 4'hF, 4'h0, 0, 4'h0, 4'hF, 4'h0, 1);
    add(0, 4'hF, 4'h0, 0, 4'hF, 4'hF, 4'h0, 1);

    foreach (vecs[k]) begin
      exp_t x;
      rst = vecs[k].rst; i_pin = vecs[k].i; ib_pin = vecs[k].ib; err_clr = vecs[k].clr;
      x.o = vecs[k].o; x.valid = vecs[k].valid; x.err = vecs[k].err; x.vchk = vecs[k].vchk; x.idx = k;
      sb.push_back(x);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      ob_exp = ~e.o;
      check($sformatf("v%0d O", e.idx), o, e.o);
      check($sformatf("v%0d OB", e.idx), ob, ob_exp);
      if (e.vchk) check($sformatf("v%0d VALID", e.idx), valid, e.valid);
      check($sformatf("v%0d ERR", e.idx), err, e.err);
    end

    // ch2 held invalid: ERR appears on the 6th edge, a clear while saturated sticks
    i_pin = 4'hF; ib_pin = 4'h4; err_clr = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (err[2]) begin
        cyc = c;
        break;
      end
    end
    check("timeout edge", cyc, 6);
    check("timeout VALID", valid, 4'hB);
    check("timeout ERR", err, 4'h4);
    check("timeout O", o, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("saturated clear ERR", err, 4'h0);
    @(posedge clk);
    #1;
    check("saturated no reset ERR", err, 4'h0);
    check("saturated VALID", valid, 4'hB);
    ib_pin = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("recover VALID", valid, 4'hF);
    check("recover O", o, 4'hF);

`ifdef IBUFDS_DIFF_FILTER_POL_INV_EN
    rst = 1'b1; i_pin = 4'h0; ib_pin = 4'hF; inv = 4'h1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("inv edge%0d O", k), o, (k == 5) ? 4'h1 : 4'h0);
    end
    check("inv OB", ob, 4'hE);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ibufds_diff_filter.md
IBUFDS_DIFF_FILTER -- requirements
Module: ibufds_diff_filter

Interface
REQ-001 Parameter WIDTH, default 4: number of independent differential channels, range 1..32.
REQ-002 Parameter FILTER_LEN, default 3: consecutive valid differing samples needed to change O, range 1..255.
REQ-003 Parameter INV_LIMIT, default 4: consecutive invalid-pair samples before a channel is flagged, range 1..255.
REQ-004 Parameter IOSTANDARD, default "LVDS_25": informational only, no functional effect.
REQ-005 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 RST  input  1  synchronous, active-high reset.
REQ-007 I  input  WIDTH  true leg of each differential pair, asynchronous to CLK.
REQ-008 IB  input  WIDTH  complement leg of each pair, asynchronous to CLK.
REQ-009 ERR_CLR  input  1  single-cycle pulse that clears all ERR bits.
REQ-010 O  output  WIDTH  filtered, registered decoded level per channel.
REQ-011 OB  output  WIDTH  always the bitwise inverse of O.
REQ-012 VALID  output  WIDTH  channel's most recent synchronised pair is differential and not in invalid timeout.
REQ-013 ERR  output  WIDTH  sticky flag: the channel reached INV_LIMIT consecutive invalid samples.

Function
REQ-014 I and IB each pass through a two-flop synchroniser per bit; s_i and s_ib are the second-stage outputs.
REQ-015 A sample is valid when s_i != s_ib, with candidate value s_i; it is invalid when s_i == s_ib.
REQ-016 Filter counter fcnt, width clog2(FILTER_LEN+1): on a valid sample equal to O, fcnt <= 0.
REQ-017 On a valid sample differing from O: if fcnt == FILTER_LEN-1 then O <= candidate and fcnt <= 0; otherwise fcnt <= fcnt+1.
REQ-018 On an invalid sample, O and fcnt hold their values; invalid samples neither advance nor clear the filter.
REQ-019 Latency: a pin change held stable updates O on the (FILTER_LEN+2)th rising edge after first capture; FILTER_LEN=1 gives 3 edges.
REQ-020 Invalid counter icnt, width clog2(INV_LIMIT+1): +1 per invalid sample, saturating at INV_LIMIT; any valid sample clears it to 0.
REQ-021 VALID[n] <= 1 on a valid sample; VALID[n] <= 0 on the edge where icnt[n] reaches INV_LIMIT.
REQ-022 ERR[n] <= 1 on the edge where icnt[n] reaches INV_LIMIT, and stays 1 until ERR_CLR or RST.
REQ-023 ERR_CLR clears every ERR bit; if a set and ERR_CLR occur on the same edge for a channel, the set wins.
REQ-024 Channels are fully independent; no channel's state affects another's.
REQ-025 OB is derived combinationally from O with no extra delay.

Reset
REQ-026 On RST: O=0, OB=all 1, VALID=0, ERR=0, all fcnt and icnt 0.
REQ-027 On RST, synchroniser flops for I load 0 and flops for IB load 1, so that no invalid sample is seen during the first two cycles after reset.
REQ-028 RST asserted mid-filter or mid-timeout discards all partial counts; RST overrides ERR_CLR.

Configuration
REQ-029 Macro IBUFDS_DIFF_FILTER_POL_INV_EN defined: add input INV (width WIDTH); when INV[n]=1, the candidate is ~s_i for channel n; INV changes take effect through the filter like a data change.
REQ-030 Macro IBUFDS_DIFF_FILTER_POL_INV_EN undefined: INV port is absent and the candidate is always s_i.

Verification
REQ-031 Reset release with I=4'hF and IB=4'h0, FILTER_LEN=3 -> O=4'h0 for 4 edges, O=4'hF on the 5th edge, VALID=4'hF from the 3rd edge.
REQ-032 Channel 0 toggles I/IB for 2 cycles then returns -> O[0] never changes, and fcnt returns to 0.
REQ-033 Channel 1 held I=IB=1 for 4 cycles, INV_LIMIT=4 -> O[1] held, VALID[1]=0 and ERR[1]=1 on the 4th invalid sample; ERR[1] stays 1 after the pair recovers.
REQ-034 ERR_CLR pulsed on the same edge that channel 2 reaches INV_LIMIT -> ERR[2]=1; a later ERR_CLR with no new set -> ERR=0.
REQ-035 Channel 3 sequence: valid differing, invalid, valid differing, valid differing -> O[3] changes after the 3rd valid sample, with the invalid sample skipped.
REQ-036 With IBUFDS_DIFF_FILTER_POL_INV_EN defined, INV=4'h1 and static I=4'h0/IB=4'hF -> O=4'h1 after FILTER_LEN+2 edges, and OB=4'hE.
